// File: rtl/voice_pkg.sv
// Shared sizing and FSM state encoding for the voice allocator.
package voice_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int RANK_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RELEASE,
    ST_ALLOC
  } state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Key-gate input and voice-state outputs of the allocator, bundled as one port.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = voice_pkg::NUM_KEYS,
  parameter int NUM_VOICES = voice_pkg::NUM_VOICES,
  parameter int KEY_W      = voice_pkg::KEY_W
);

  logic [NUM_KEYS-1:0]              key_gate_in;
  logic [NUM_VOICES-1:0]            voice_active_out;
  logic [NUM_VOICES-1:0][KEY_W-1:0] voice_key_out;
  logic [NUM_VOICES-1:0]            voice_trig_out;
  logic                             drop_out;
  logic                             busy_out;

  // The allocator consumes key gates and publishes voice state.
  modport slave (
    input  key_gate_in,
    output voice_active_out, voice_key_out, voice_trig_out, drop_out, busy_out
  );

  modport master (
    output key_gate_in,
    input  voice_active_out, voice_key_out, voice_trig_out, drop_out, busy_out
  );

endinterface

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder with a valid flag.
module prio_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Allocates touch keys to a small pool of synth voices with LRU ranking.
// Define VOICE_STEAL_EN to steal the oldest voice when none is free; otherwise the press is dropped.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_KEYS   = voice_pkg::NUM_KEYS,
  parameter int NUM_VOICES = voice_pkg::NUM_VOICES
) (
  input  logic             clk_in,
  input  logic             rst_in,
  voice_allocator_if.slave bus
);

  localparam int KEY_BITS  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int RANK_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0]                 gate_prev_q;
  logic [NUM_KEYS-1:0]                 pend_press_q, pend_press_d;
  logic [NUM_KEYS-1:0]                 pend_rel_q, pend_rel_d;
  state_e                              state_q, state_d;
  logic [KEY_BITS-1:0]                 cur_key_q, cur_key_d;
  logic [NUM_VOICES-1:0]               active_q, active_d;
  logic [NUM_VOICES-1:0][KEY_BITS-1:0] vkey_q, vkey_d;
  logic [NUM_VOICES-1:0][RANK_BITS-1:0] rank_q, rank_d;
  logic [NUM_VOICES-1:0]               trig_q, trig_d;
  logic                                drop_q, drop_d;
  logic                                busy_d;

  logic [NUM_KEYS-1:0]   rise, fall, held;
  logic [NUM_VOICES-1:0] hit_vec;
  logic [KEY_BITS-1:0]   rel_idx, press_idx;
  logic [RANK_BITS-1:0]  free_idx, hit_idx, tgt;
  logic                  rel_valid, press_valid, free_valid, hit_valid, do_trig;

  assign rise = bus.key_gate_in & ~gate_prev_q;
  assign fall = ~bus.key_gate_in & gate_prev_q;

  // A key counts as held while the ALLOC pass for it is committing, so a
  // release landing on that same edge is not lost.
  always_comb begin
    held    = '0;
    hit_vec = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (state_q == ST_ALLOC && cur_key_q == KEY_BITS'(k)) held[k] = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (active_q[v] && vkey_q[v] == KEY_BITS'(k)) held[k] = 1'b1;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit_vec[v] = active_q[v] && (vkey_q[v] == cur_key_q);
    end
  end

  prio_enc #(.WIDTH(NUM_KEYS), .IDX_W(KEY_BITS)) u_rel_enc (
    .req_i(pend_rel_q), .idx_o(rel_idx), .valid_o(rel_valid)
  );
  prio_enc #(.WIDTH(NUM_KEYS), .IDX_W(KEY_BITS)) u_press_enc (
    .req_i(pend_press_q), .idx_o(press_idx), .valid_o(press_valid)
  );
  prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(RANK_BITS)) u_free_enc (
    .req_i(~active_q), .idx_o(free_idx), .valid_o(free_valid)
  );
  prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(RANK_BITS)) u_hit_enc (
    .req_i(hit_vec), .idx_o(hit_idx), .valid_o(hit_valid)
  );

`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES-1:0] oldest_vec;
  logic [RANK_BITS-1:0]  oldest_idx;
  logic                  oldest_valid;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      oldest_vec[v] = (rank_q[v] == RANK_BITS'(NUM_VOICES - 1));
    end
  end

  prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(RANK_BITS)) u_oldest_enc (
    .req_i(oldest_vec), .idx_o(oldest_idx), .valid_o(oldest_valid)
  );
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cur_key_d    = cur_key_q;
    pend_press_d = pend_press_q;
    pend_rel_d   = pend_rel_q;
    active_d     = active_q;
    vkey_d       = vkey_q;
    rank_d       = rank_q;
    trig_d       = '0;
    drop_d       = 1'b0;
    tgt          = '0;
    do_trig      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rel_valid) begin
          cur_key_d = rel_idx;
          state_d   = ST_RELEASE;
        end else if (press_valid) begin
          cur_key_d = press_idx;
          state_d   = ST_ALLOC;
        end
      end
      ST_RELEASE: begin
        if (hit_valid) active_d[hit_idx] = 1'b0;
        pend_rel_d[cur_key_q] = 1'b0;
        state_d               = ST_IDLE;
      end
      ST_ALLOC: begin
        pend_press_d[cur_key_q] = 1'b0;
        state_d                 = ST_IDLE;
        // A tap that fell after being latched has been cancelled; skip it.
        if (pend_press_q[cur_key_q]) begin
          if (hit_valid) begin
            tgt     = hit_idx;
            do_trig = 1'b1;
          end else if (free_valid) begin
            tgt     = free_idx;
            do_trig = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            tgt     = oldest_idx;
            do_trig = oldest_valid;
            drop_d  = ~oldest_valid;
`else
            drop_d  = 1'b1;
`endif
          end
        end
        if (do_trig) begin
          active_d[tgt] = 1'b1;
          vkey_d[tgt]   = cur_key_q;
          trig_d[tgt]   = 1'b1;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (rank_q[v] < rank_q[tgt]) rank_d[v] = rank_q[v] + 1'b1;
          end
          rank_d[tgt] = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Gate edges are merged last: a fall cancels any unserviced press of that key.
    pend_press_d = (pend_press_d | rise) & ~fall;
    pend_rel_d   = pend_rel_d | (fall & held);
  end

  assign busy_d = (|pend_press_d) | (|pend_rel_d) | (state_d != ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gate_prev_q  <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      state_q      <= ST_IDLE;
      cur_key_q    <= '0;
      active_q     <= '0;
      // NOTE: the voice key table is a handful of flops feeding outputs, so it is reset rather than left undefined.
      vkey_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= RANK_BITS'(v);
      trig_q       <= '0;
      drop_q       <= 1'b0;
      bus.voice_active_out <= '0;
      bus.voice_key_out    <= '0;
      bus.voice_trig_out   <= '0;
      bus.drop_out         <= 1'b0;
      bus.busy_out         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      gate_prev_q  <= bus.key_gate_in;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      state_q      <= state_d;
      cur_key_q    <= cur_key_d;
      active_q     <= active_d;
      vkey_q       <= vkey_d;
      rank_q       <= rank_d;
      trig_q       <= trig_d;
      drop_q       <= drop_d;
      bus.voice_active_out <= active_q;
      bus.voice_key_out    <= vkey_q;
      bus.voice_trig_out   <= trig_q;
      bus.drop_out         <= drop_q;
      bus.busy_out         <= busy_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench: expected trig/drop events are queued with their due edge and matched as the DUT emits them.
module tb_voice_allocator;
  import voice_pkg::*;

  typedef struct {
    int unsigned           edge_no;
    logic [NUM_VOICES-1:0] trig;
    logic                  drop;
    logic [KEY_W-1:0]      key;
  } evt_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  voice_allocator_if bus ();

  voice_allocator dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int unsigned edge_cnt = 0;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  evt_t        sb_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, exp_v, edge_cnt);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic expect_trig(int unsigned ed, int v, int key);
    evt_t e;
    e.edge_no = ed;
    e.trig    = '0;
    e.trig[v] = 1'b1;
    e.drop    = 1'b0;
    e.key     = KEY_W'(key);
    sb_q.push_back(e);
  endtask

  task automatic expect_drop(int unsigned ed);
    evt_t e;
    e.edge_no = ed;
    e.trig    = '0;
    e.drop    = 1'b1;
    e.key     = '0;
    sb_q.push_back(e);
  endtask

  // Bounded wait for the allocator to drain, plus two edges for the output stage.
  task automatic wait_idle();
    int cnt = 0;
    tick(1);
    while (bus.busy_out === 1'b1 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("idle_reached", bus.busy_out, 0);
    tick(2);
  endtask

  // Output monitor: every trig/drop pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    evt_t e;
    if (sb_q.size() > 0 && sb_q[0].edge_no < edge_cnt) begin
      check("evt_missing", edge_cnt, sb_q[0].edge_no);
      void'(sb_q.pop_front());
    end
    if ((|bus.voice_trig_out) || bus.drop_out) begin
      if (sb_q.size() == 0) begin
        check("evt_unexpected", {bus.voice_trig_out, bus.drop_out}, 0);
      end else begin
        e = sb_q.pop_front();
        check("evt_edge", edge_cnt, e.edge_no);
        check("evt_trig", bus.voice_trig_out, e.trig);
        check("evt_drop", bus.drop_out, e.drop);
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (e.trig[v]) check("evt_key", bus.voice_key_out[v], e.key);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    bus.key_gate_in = '0;

    // Reset state
    tick(3);
    check("rst_active", bus.voice_active_out, 0);
    check("rst_key", bus.voice_key_out, 0);
    check("rst_trig", bus.voice_trig_out, 0);
    check("rst_drop", bus.drop_out, 0);
    check("rst_busy", bus.busy_out, 0);
    rst_in = 1'b1;
    tick(3);
    check("idle_busy", bus.busy_out, 0);

    // Single press of key 3: outputs appear exactly 3 edges after first sample
    base = edge_cnt + 1;
    bus.key_gate_in[3] = 1'b1;
    expect_trig(base + 3, 0, 3);
    tick(3);
    check("t1_not_early", bus.voice_active_out, 0);
    tick(1);
    check("t1_active", bus.voice_active_out, 32'h1);
    check("t1_key", bus.voice_key_out[0], 3);
    wait_idle();
    base = edge_cnt + 1;
    bus.key_gate_in[3] = 1'b0;
    tick(3);
    check("t1_rel_not_early", bus.voice_active_out, 32'h1);
    tick(1);
    check("t1_released", bus.voice_active_out, 0);
    wait_idle();

    // Simultaneous presses of keys 1 and 5
    base = edge_cnt + 1;
    bus.key_gate_in[1] = 1'b1;
    bus.key_gate_in[5] = 1'b1;
    expect_trig(base + 3, 0, 1);
    expect_trig(base + 5, 1, 5);
    wait_idle();
    check("t2_active", bus.voice_active_out, 32'h3);
    check("t2_key1", bus.voice_key_out[1], 5);
    bus.key_gate_in = '0;
    wait_idle();
    check("t2_released", bus.voice_active_out, 0);

    // Fill all voices with keys 0..3, then press key 7 with none free
    base = edge_cnt + 1;
    for (int k = 0; k < 4; k++) begin
      bus.key_gate_in[k] = 1'b1;
      expect_trig(base + 3 + 2 * k, k, k);
    end
    wait_idle();
    check("t3_full", bus.voice_active_out, 32'hF);
    base = edge_cnt + 1;
    bus.key_gate_in[7] = 1'b1;
`ifdef VOICE_STEAL_EN
    expect_trig(base + 3, 0, 7);
`else
    expect_drop(base + 3);
`endif
    wait_idle();
    check("t3_active_after", bus.voice_active_out, 32'hF);
`ifdef VOICE_STEAL_EN
    check("t3_v0_key", bus.voice_key_out[0], 7);
`else
    check("t3_v0_key", bus.voice_key_out[0], 0);
`endif
    check("t3_v3_key", bus.voice_key_out[3], 3);
    bus.key_gate_in = '0;
    wait_idle();
    check("t3_released", bus.voice_active_out, 0);

    // One-cycle tap of key 4 while the FSM is busy with keys 8, 9, 10
    base = edge_cnt + 1;
    bus.key_gate_in[8]  = 1'b1;
    bus.key_gate_in[9]  = 1'b1;
    bus.key_gate_in[10] = 1'b1;
    expect_trig(base + 3, 0, 8);
    expect_trig(base + 5, 1, 9);
    expect_trig(base + 7, 2, 10);
    tick(1);
    check("t4_busy", bus.busy_out, 1);
    bus.key_gate_in[4] = 1'b1;
    tick(1);
    bus.key_gate_in[4] = 1'b0;
    wait_idle();
    check("t4_active", bus.voice_active_out, 32'h7);
    bus.key_gate_in = '0;
    wait_idle();

    // Release of key 6 and press of key 9 pending together: release first
    base = edge_cnt + 1;
    bus.key_gate_in[0] = 1'b1;
    bus.key_gate_in[1] = 1'b1;
    bus.key_gate_in[2] = 1'b1;
    bus.key_gate_in[6] = 1'b1;
    expect_trig(base + 3, 0, 0);
    expect_trig(base + 5, 1, 1);
    expect_trig(base + 7, 2, 2);
    expect_trig(base + 9, 3, 6);
    wait_idle();
    base = edge_cnt + 1;
    bus.key_gate_in[6] = 1'b0;
    bus.key_gate_in[9] = 1'b1;
    expect_trig(base + 5, 3, 9);
    tick(4);
    check("t5_freed_first", bus.voice_active_out, 32'h7);
    wait_idle();
    check("t5_active", bus.voice_active_out, 32'hF);
    check("t5_v3_key", bus.voice_key_out[3], 9);
    bus.key_gate_in = '0;
    wait_idle();

    // Reset asserted mid-ALLOC of key 2 while key 5 holds voice 0
    base = edge_cnt + 1;
    bus.key_gate_in[5] = 1'b1;
    expect_trig(base + 3, 0, 5);
    wait_idle();
    check("t6_pre_active", bus.voice_active_out, 32'h1);
    bus.key_gate_in[2] = 1'b1;
    tick(2);
    check("t6_busy", bus.busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("t6_rst_active", bus.voice_active_out, 0);
    check("t6_rst_key", bus.voice_key_out, 0);
    check("t6_rst_trig", bus.voice_trig_out, 0);
    check("t6_rst_drop", bus.drop_out, 0);
    check("t6_rst_busy", bus.busy_out, 0);
    sb_q.delete();
    tick(2);
    rst_in = 1'b1;
    base = edge_cnt + 1;
    expect_trig(base + 3, 0, 2);
    expect_trig(base + 5, 1, 5);
    wait_idle();
    check("t6_realloc_active", bus.voice_active_out, 32'h3);
    check("t6_v0_key", bus.voice_key_out[0], 2);
    check("t6_v1_key", bus.voice_key_out[1], 5);
    bus.key_gate_in = '0;
    wait_idle();
    check("final_active", bus.voice_active_out, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
- REQ-001: Parameter NUM_KEYS SHALL default to 12; it is the number of touch keys.
- REQ-002: Parameter NUM_VOICES SHALL default to 4; it is the number of synth voices shared between keys.
- REQ-003: clk_in, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
- REQ-004: rst_in, input, 1 bit, SHALL be an asynchronous, active-low reset.
- REQ-005: key_gate_in, input, NUM_KEYS bits, SHALL carry the level per key, 1 = touched (direct from touch decoder gate).
- REQ-006: voice_active_out, output, NUM_VOICES bits, SHALL be 1 per voice currently holding a key.
- REQ-007: voice_key_out, output, NUM_VOICES x KEY_W bits, SHALL give the key index held by each voice; KEY_W = clog2(NUM_KEYS).
- REQ-008: voice_trig_out, output, NUM_VOICES bits, SHALL pulse for one cycle on the voice being (re)allocated.
- REQ-009: drop_out, output, 1 bit, SHALL pulse for one cycle when a press is discarded.
- REQ-010: busy_out, output, 1 bit, SHALL be 1 whenever any press or release is pending or the FSM is not IDLE.

Function
- REQ-011: key_gate_in SHALL be registered once (gate_prev); rise = gate & ~gate_prev sets pend_press[k]; fall sets pend_rel[k] only if key k is held by a voice.
- REQ-012: A fall on key k SHALL clear pend_press[k] in the same cycle, so an unserviced tap is silently cancelled.
- REQ-013: FSM states SHALL be IDLE, RELEASE and ALLOC; one event per pass; each pass is 2 cycles.
- REQ-014: In IDLE, if pend_rel != 0, the FSM SHALL latch the lowest-index released key and go to RELEASE; otherwise, if pend_press != 0, it SHALL latch the lowest-index pressed key and go to ALLOC; otherwise it SHALL stay in IDLE.
- REQ-015: Releases SHALL have priority over presses in IDLE.
- REQ-016: RELEASE SHALL clear voice_active_out of the voice holding the latched key, clear its pend_rel bit, and return to IDLE.
- REQ-017: ALLOC SHALL pick the lowest-index free voice, write voice_key_out, set voice_active_out, pulse voice_trig_out, give that voice LRU rank 0, clear pend_press, and return to IDLE.
- REQ-018: LRU ranks SHALL be a per-voice clog2(NUM_VOICES) counter; on allocation, voices whose rank is below the allocated voice's old rank SHALL increment; the oldest voice has rank NUM_VOICES-1.
- REQ-019: Latency SHALL be fixed: for a press first sampled at edge k with FSM idle, voice outputs and voice_trig_out SHALL be asserted after edge k+3.
- REQ-020: A press on a key already held by a voice SHALL retrigger that same voice, not allocate a second one.
- REQ-021: A press arriving while the FSM is mid-pass SHALL stay pending and not be lost.

Reset
- REQ-022: Asserting rst_in SHALL immediately clear gate_prev, pend_press, pend_rel, voice_active_out, voice_key_out, voice_trig_out, drop_out and busy_out, reset LRU ranks to the voice index, and set the FSM to IDLE, including mid-pass.
- REQ-023: Keys held across reset deassertion SHALL be treated as new presses.

Configuration
- REQ-024: With VOICE_STEAL_EN defined, ALLOC with no free voice SHALL steal the voice with rank NUM_VOICES-1, overwrite its key, pulse voice_trig_out, and set its rank to 0.
- REQ-025: Without VOICE_STEAL_EN, ALLOC with no free voice SHALL clear the pend_press bit, pulse drop_out, and leave all voices unchanged.

Structure
- REQ-026: Package voice_pkg SHALL hold NUM_KEYS, NUM_VOICES, KEY_W, the LRU rank width and the FSM state enum.
- REQ-027: Sub-module prio_enc (parameterised lowest-set-bit encoder with a valid flag) SHALL be used for key selection and for free-voice selection.

Verification
- REQ-028: Press key 3 alone from reset -> after edge k+3, voice 0 active, key 3, one trig pulse; release -> voice 0 inactive 3 edges after the fall.
- REQ-029: Keys 1 and 5 rise in the same cycle -> key 1 goes to voice 0, then key 5 to voice 1, two cycles later.
- REQ-030: Keys 0, 1, 2, 3 held, then key 7 pressed -> with VOICE_STEAL_EN, voice 0 is re-keyed to 7 with a trig pulse; without it, one drop_out pulse and voices unchanged.
- REQ-031: Key 4 tapped high for exactly 1 cycle while the FSM is busy with other events -> no allocation, no trig and no drop for key 4.
- REQ-032: Assert rst_in mid-ALLOC with key 2 held -> all outputs are 0 asynchronously; after deassertion key 2 is reallocated to voice 0.
- REQ-033: Release of key 6 and press of key 9 pending together -> the release is serviced first and key 9 takes the freed voice.
